// File: rtl/mips_pkg.sv
// Shared constants and write-back source selection for the MIPS pipeline slice.
package mips_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int REG_CNT     = 32;
  localparam int REG_ZERO    = 0;
  localparam int REG_RA      = 31;
  localparam int LINK_OFFSET = 4;

  // Where the write-back value comes from.
  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_LINK = 2'd2
  } wb_src_e;

  // A link (JAL/JALR) takes precedence over a load if both flags are raised.
  function automatic wb_src_e wb_src_sel(input logic link_en, input logic mem_r_en);
    if (link_en)
      return WB_SRC_LINK;
    else if (mem_r_en)
      return WB_SRC_MEM;
    else
      return WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Architectural register array: async clear, one write port, two raw read ports.
// Entry 0 is never written, so it always holds zero.
module reg_file_2r1w
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [REG_CNT];

  // Clear every entry on reset; otherwise commit one write per edge, skipping entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != ADDR_W'(REG_ZERO))) begin
      regs[waddr] <= wdata;
    end
  end

  // Raw reads; zero-index and bypass handling are done by the caller.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage: selects the write-back value, commits it to the register file,
// serves two bypassed read ports to ID and keeps retire statistics.
module wb_stage_regfile
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              link_en,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_read_value,
  input  logic [ADDR_W-1:0] dest,
  input  logic [31:0]       pc,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] wb_value,
  output logic              wb_commit,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [31:0]       last_pc
);

  wb_src_e           wb_src;
  logic [DATA_W-1:0] raw_data1;
  logic [DATA_W-1:0] raw_data2;

  assign wb_src = wb_src_sel(link_en, mem_r_en);

  // Write-back source mux; link address wraps modulo 2^32.
  always_comb begin
    case (wb_src)
      WB_SRC_LINK: wb_value = DATA_W'(pc + 32'(LINK_OFFSET));
      WB_SRC_MEM:  wb_value = mem_read_value;
      default:     wb_value = alu_result;
    endcase
  end

  // A bubble or a write to $0 never produces a write strobe.
  assign wb_commit = wb_valid & wb_en & (dest != ADDR_W'(REG_ZERO));

  reg_file_2r1w u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_commit),
    .waddr  (dest),
    .wdata  (wb_value),
    .raddr1 (rd_addr1),
    .raddr2 (rd_addr2),
    .rdata1 (raw_data1),
    .rdata2 (raw_data2)
  );

  // Read port 1: $0 reads zero, then same-cycle write bypass, then stored value.
  always_comb begin
    rd_data1 = raw_data1;
    if (rd_addr1 == ADDR_W'(REG_ZERO))
      rd_data1 = '0;
    else if (wb_commit && (dest == rd_addr1))
      rd_data1 = wb_value;
  end

  // Read port 2: same resolution as port 1, evaluated independently.
  always_comb begin
    rd_data2 = raw_data2;
    if (rd_addr2 == ADDR_W'(REG_ZERO))
      rd_data2 = '0;
    else if (wb_commit && (dest == rd_addr2))
      rd_data2 = wb_value;
  end

  // Every valid instruction retires, whether or not it writes a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_cnt <= '0;
      last_pc     <= '0;
    end else if (wb_valid) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
      last_pc     <= pc;
    end
  end

endmodule
